// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
// Event layout, prefix bytes, frame FSM states and the odd-parity helper.
package ps2_pkg;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } frame_state_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^data ^ parity;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO; dout always presents the head entry.
// A push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // NOTE: the storage array has no reset; only pointers and count need one,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronise, deglitch, deserialise, validate,
// fold E0/F0 prefixes into key events and queue them for the consumer.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [7:0]                      ev_code,
  output logic                            ev_extended,
  output logic                            ev_release,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic                            err_parity,
  output logic                            err_frame,
  output logic                            err_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, clk_flt_d, strobe;

  frame_state_t  state_q, state_d;
  logic [10:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          ext_q, rel_q;

  logic          in_check, start_ok, stop_ok, par_ok, good, push, pop;
  logic [7:0]    rx_byte;
  logic          fifo_full, fifo_empty;
  ps2_event_t    push_ev, head_ev;

  // Idle level of both lines is 1, so reset to 1 to avoid a false edge.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      clk_flt_d <= clk_flt;
      if (clk_s2 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_flt <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign strobe = clk_flt_d & ~clk_flt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE:  if (strobe) state_d = RECV;
      RECV: begin
        if (strobe && bit_cnt == 4'd10) begin
          state_d = CHECK;
        end else if (!strobe && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame layout after eleven LSB-first shifts: [0] start, [8:1] data, [9] parity, [10] stop.
  assign in_check = (state_q == CHECK);
  assign rx_byte  = shreg[8:1];
  assign start_ok = ~shreg[0];
  assign stop_ok  = shreg[10];
  assign par_ok   = odd_parity_ok(rx_byte, shreg[9]);
  assign good     = in_check && start_ok && stop_ok && par_ok;
  assign push     = good && (rx_byte != PS2_PFX_EXT) && (rx_byte != PS2_PFX_BRK);
  assign push_ev  = '{extended: ext_q, released: rel_q, code: rx_byte};
  assign pop      = ev_valid && ev_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_parity   <= in_check && !par_ok;
      err_frame    <= (in_check && !(start_ok && stop_ok)) || timeout;
      err_overflow <= push && fifo_full && !pop;

      if (strobe) shreg <= {dat_s2, shreg[10:1]};

      if (state_q == RECV && !timeout) begin
        if (strobe) bit_cnt <= bit_cnt + 4'd1;
      end else if (state_q == IDLE && strobe) begin
        bit_cnt <= 4'd1;
      end else begin
        bit_cnt <= '0;
      end

      if (state_q == RECV && !strobe && !timeout) to_cnt <= to_cnt + TW'(1);
      else                                        to_cnt <= '0;

      if (timeout || (in_check && !good)) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (good) begin
        if (rx_byte == PS2_PFX_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_PFX_BRK) begin
          rel_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          rel_q <= 1'b0;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH($bits(ps2_event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ev),
    .dout  (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ev_valid    = ~fifo_empty;
  assign ev_code     = ev_valid ? head_ev.code : 8'h00;
  assign ev_extended = ev_valid & head_ev.extended;
  assign ev_release  = ev_valid & head_ev.released;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: frames are bit-banged at an 80-cycle
// PS/2 period with a 1 MHz system clock so the timeout is 200 cycles.
module tb_ps2_scan_decoder;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data, ev_ready;
  logic [7:0] ev_code;
  logic       ev_extended, ev_release, ev_valid;
  logic       err_parity, err_frame, err_overflow;
  logic [3:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int n_par = 0, n_frm = 0, n_ovf = 0, n_strobe = 0;
  int p0, f0, o0, s0;
  bit ok;

  ps2_scan_decoder #(
    .CLK_FREQ_HZ(1_000_000),
    .TIMEOUT_US (200),
    .FILTER_LEN (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ev_code     (ev_code),
    .ev_extended (ev_extended),
    .ev_release  (ev_release),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overflow(err_overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_parity)   n_par++;
    if (err_frame)    n_frm++;
    if (err_overflow) n_ovf++;
    if (dut.strobe)   n_strobe++;
  end

  initial begin
    #700_000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic flip_par);
    return {1'b1, (~^code) ^ flip_par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cycles(20);
      ps2_clk = 1'b0;
      wait_cycles(40);
      ps2_clk = 1'b1;
      wait_cycles(20);
    end
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_bits(make_frame(code, 1'b0), 11);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  // Sends bits 0..9 then drops ps2_clk for the stop bit and returns in the
  // negedge where the stop-bit strobe is seen; caller must finish the bit.
  task automatic send_to_stop_strobe(input logic [7:0] code, output bit seen);
    seen = 1'b0;
    send_bits(make_frame(code, 1'b0), 10);
    ps2_data = 1'b1;
    wait_cycles(20);
    ps2_clk = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dut.strobe) seen = 1'b1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b0;
    wait_cycles(3);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_code", 32'(ev_code), 32'h0);
    check("rst_errs", 32'({err_parity, err_frame, err_overflow}), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    reset = 1'b0;
    wait_cycles(20);

    // Good 0x1C with exact latency from the stop-bit strobe.
    p0 = n_par; f0 = n_frm;
    send_to_stop_strobe(8'h1C, ok);
    check("lat_strobe_seen", 32'(ok), 32'h1);
    @(negedge clk);
    check("lat_valid_t1", 32'(ev_valid), 32'h0);
    @(negedge clk);
    check("lat_valid_t2", 32'(ev_valid), 32'h1);
    wait_cycles(30);
    ps2_clk = 1'b1;
    wait_cycles(20);
    check("1c_code", 32'(ev_code), 32'h1C);
    check("1c_flags", 32'({ev_extended, ev_release}), 32'h0);
    check("1c_no_err", 32'((n_par - p0) + (n_frm - f0)), 32'h0);
    pop_one();
    check("1c_popped_level", 32'(fifo_level), 32'h0);

    // E0 F0 75 and F0 E0 12 each fold into one extended break event.
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("pfx_no_push", 32'(fifo_level), 32'h0);
    send_byte(8'h75);
    check("e0f0_level", 32'(fifo_level), 32'h1);
    check("e0f0_event", 32'({ev_extended, ev_release, ev_code}), 32'h375);
    pop_one();
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h12);
    check("f0e0_event", 32'({ev_extended, ev_release, ev_code}), 32'h312);
    pop_one();

    // Parity error drops the byte and clears a pending E0.
    p0 = n_par; f0 = n_frm;
    send_byte(8'hE0);
    send_bits(make_frame(8'h1C, 1'b1), 11);
    check("par_pulse", 32'(n_par - p0), 32'h1);
    check("par_no_frame", 32'(n_frm - f0), 32'h0);
    check("par_level", 32'(fifo_level), 32'h0);
    send_byte(8'h1B);
    check("after_par_event", 32'({ev_extended, ev_release, ev_code}), 32'h01B);
    pop_one();

    // Partial frame then silence: one timeout, back to IDLE.
    f0 = n_frm;
    send_bits(make_frame(8'h29, 1'b0), 5);
    wait_cycles(300);
    check("to_pulse", 32'(n_frm - f0), 32'h1);
    check("to_idle", 32'(dut.state_q), 32'(IDLE));
    check("to_level", 32'(fifo_level), 32'h0);
    send_byte(8'h29);
    check("after_to_event", 32'({ev_extended, ev_release, ev_code}), 32'h029);
    check("idle_no_to", 32'(n_frm - f0), 32'h1);
    pop_one();

    // Fill the FIFO, overflow once, then push and pop in the same cycle.
    o0 = n_ovf;
    for (int i = 0; i < 8; i++) send_byte(8'h15 + 8'(i));
    check("full_level", 32'(fifo_level), 32'h8);
    check("full_no_ovf", 32'(n_ovf - o0), 32'h0);
    send_byte(8'h1D);
    check("ovf_pulse", 32'(n_ovf - o0), 32'h1);
    check("ovf_level", 32'(fifo_level), 32'h8);
    check("ovf_head", 32'(ev_code), 32'h15);
    send_to_stop_strobe(8'h2A, ok);
    check("simul_strobe_seen", 32'(ok), 32'h1);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    wait_cycles(3);
    check("simul_level", 32'(fifo_level), 32'h8);
    check("simul_no_ovf", 32'(n_ovf - o0), 32'h1);
    check("simul_head", 32'(ev_code), 32'h16);
    wait_cycles(30);
    ps2_clk = 1'b1;
    wait_cycles(20);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(ev_code), (i < 7) ? 32'h16 + 32'(i) : 32'h2A);
      pop_one();
    end
    check("drain_empty", 32'({ev_valid, fifo_level}), 32'h0);

    // Glitch one cycle shorter than the filter: no strobe.
    s0 = n_strobe;
    ps2_clk = 1'b0;
    wait_cycles(7);
    ps2_clk = 1'b1;
    wait_cycles(30);
    check("glitch_no_strobe", 32'(n_strobe - s0), 32'h0);
    send_byte(8'h1C);
    check("after_glitch_event", 32'({ev_extended, ev_release, ev_code}), 32'h01C);

    // Reset in the middle of a frame with an event queued and E0 pending.
    send_byte(8'hE0);
    send_bits(make_frame(8'h4B, 1'b0), 6);
    reset = 1'b1;
    wait_cycles(2);
    check("midrst_valid", 32'(ev_valid), 32'h0);
    check("midrst_outs", 32'({ev_extended, ev_release, ev_code, fifo_level}), 32'h0);
    reset = 1'b0;
    wait_cycles(20);
    p0 = n_par; f0 = n_frm;
    send_byte(8'h4B);
    check("after_rst_event", 32'({ev_extended, ev_release, ev_code}), 32'h04B);
    check("after_rst_level", 32'(fifo_level), 32'h1);
    check("after_rst_no_err", 32'((n_par - p0) + (n_frm - f0)), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Parametrised successor to the basic PS/2 receiver. Runs entirely in the system clock domain: synchronises and deglitches ps2_clk/ps2_data, deserialises 11-bit frames, and checks start, odd parity and stop. It folds E0/F0 prefixes into key events, applies a mid-frame timeout, and buffers events in a FIFO with a valid/ready interface toward the game-input logic.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency.
TIMEOUT_US, 200, max gap between ps2_clk falling edges inside a frame; TIMEOUT_CYCLES = CLK_FREQ_HZ/1_000_000*TIMEOUT_US.
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required to change the filtered level (>=1).
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock from pad
ps2_data  in  1  raw PS/2 data from pad
ev_code  out  8  scan code of head event
ev_extended  out  1  head event was preceded by E0
ev_release  out  1  head event was preceded by F0 (break)
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts head event
err_parity  out  1  one-cycle pulse: parity mismatch
err_frame  out  1  one-cycle pulse: bad start/stop or timeout
err_overflow  out  1  one-cycle pulse: event dropped, FIFO full
fifo_level  out  $clog2(FIFO_DEPTH+1)  current entry count

Behaviour:
- Reset: all outputs 0; sync/filter flops and filtered clk level = 1 (idle), so no spurious edge at release; bit counter 0; prefix flags cleared; FIFO emptied. Reset mid-frame discards the partial frame.
- Input path: 2-FF synchroniser on both lines. The filtered clk changes only after FILTER_LEN equal samples. A 1→0 transition of filtered clk = sample strobe (one clk cycle); the synchronised ps2_data is shifted in LSB-first.
- Frame FSM: IDLE → RECV on first strobe (bit 0). RECV counts bits 0..10. After the 11th strobe → CHECK for one cycle, then IDLE.
- CHECK rules: start==0, stop==1, (data XOR-reduce ^ parity)==1 (odd). Parity fail → err_parity, nothing pushed. Start/stop fail → err_frame, nothing pushed. Both fail → both pulse.
- Timeout: in RECV, a cycle counter resets on each strobe. Reaching TIMEOUT_CYCLES → err_frame pulse, return to IDLE, prefix flags cleared. Never active in IDLE.
- Decode of good byte: E0 → set ext flag, no push. F0 → set rel flag, no push. Any other byte → push {ext, rel, byte}, then clear both flags. Any error also clears both flags. E0 F0 xx and F0 E0 xx both yield ext=1, rel=1.
- Latency: ev_valid (empty FIFO) rises exactly 2 clk cycles after the strobe sampling the stop bit.
- FIFO: show-ahead; ev_* reflect the head while ev_valid=1 and are 0 when empty. Pop on ev_valid&&ev_ready at a rising edge. Push when full without a simultaneous pop → drop the event and pulse err_overflow; contents unchanged. Push and pop in the same cycle when full → both succeed, level unchanged, no overflow. Pointers wrap modulo FIFO_DEPTH. ev_ready while empty is ignored.

Decomposition:
- Package ps2_pkg: typedef struct packed {logic extended; logic release; logic [7:0] code;} ps2_event_t; localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0; frame FSM state enum {IDLE, RECV, CHECK}.
- Sub-module sync_fifo #(WIDTH, DEPTH): show-ahead FIFO with push/pop/full/empty/level, reused for ps2_event_t. Filter, FSM and decode stay in ps2_scan_decoder.

Test Plan:
- Good frame 0x1C (data bits 00111000 LSB-first, parity 0, stop 1), ps2 period 80 µs → ev_valid after 2 cycles; ev_code=1C, ext=0, rel=0; no error pulses.
- Sequence E0,F0,75 → exactly one event {ext=1, rel=1, code=75}; fifo_level=1; prefixes produce no push.
- Frame 0x1C sent with parity 1 → err_parity pulse; fifo_level stays 0. Then 0x1B sent → event code=1B, ext=0, rel=0.
- 5 bits sent then idle >TIMEOUT_CYCLES → err_frame pulse once, FSM in IDLE. Next full frame 0x29 decoded correctly.
- ev_ready=0, send 9 codes with FIFO_DEPTH=8 → 9th gives err_overflow; level=8. With ev_ready=1 while full and a push arriving that cycle → no overflow, level stays 8.
- Glitch of FILTER_LEN-1 cycles low on ps2_clk → no bit sampled. Reset asserted at bit 6 → all outputs 0, and the next frame is decoded cleanly.
